// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect: cycle/burst
// type encodings, master/slave counts, the grant-state enum and the
// fixed-priority pick helper used by the arbiter.
package wb_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int NUM_SLAVES  = 3;
  localparam int ADDR_W      = 30;
  localparam int DATA_W      = 32;

  // Cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extensions
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Grant state: GRANT_Mn encodes as n+1 so the owner index is state-1
  typedef enum logic [2:0] {
    GRANT_IDLE = 3'd0,
    GRANT_M0   = 3'd1,
    GRANT_M1   = 3'd2,
    GRANT_M2   = 3'd3,
    GRANT_M3   = 3'd4
  } grant_t;

  // Highest-priority requester (m0 first), or idle when nobody requests
  function automatic grant_t pick_grant(input logic [NUM_MASTERS-1:0] req);
    if (req[0])      return GRANT_M0;
    else if (req[1]) return GRANT_M1;
    else if (req[2]) return GRANT_M2;
    else if (req[3]) return GRANT_M3;
    else             return GRANT_IDLE;
  endfunction

endpackage

// File: rtl/wb_addr_dec.sv
// Address decoder: compares a word address against each slave's base/mask
// window and returns a one-hot select (lowest slave index wins on overlap)
// plus a flag for addresses that hit no window.
module wb_addr_dec
  import wb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] S0_BASE = 30'h0000_0000,
  parameter logic [ADDR_W-1:0] S0_MASK = 30'h3800_0000,
  parameter logic [ADDR_W-1:0] S1_BASE = 30'h3000_0000,
  parameter logic [ADDR_W-1:0] S1_MASK = 30'h3C00_0000,
  parameter logic [ADDR_W-1:0] S2_BASE = 30'h3C00_0000,
  parameter logic [ADDR_W-1:0] S2_MASK = 30'h3C00_0000
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  invalid
);

  logic [ADDR_W-1:0]     base [NUM_SLAVES];
  logic [ADDR_W-1:0]     mask [NUM_SLAVES];
  logic [NUM_SLAVES-1:0] match;
  logic                  found;

  assign base[0] = S0_BASE;
  assign base[1] = S1_BASE;
  assign base[2] = S2_BASE;
  assign mask[0] = S0_MASK;
  assign mask[1] = S1_MASK;
  assign mask[2] = S2_MASK;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = ((addr & mask[gi]) == base[gi]);
    end
  endgenerate

  // Keep only the lowest-numbered matching window
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (match[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign invalid = ~|match;

endmodule

// File: rtl/wb_arbiter.sv
// Four-master / three-slave Wishbone B3 shared-bus interconnect.
// Fixed priority m0 > m1 > m2 > m3, grant held for the whole cyc (no
// preemption), direct handoff on release, combinational request routing
// and combinational ack/data return.
// Optional build macro: WB_ARB_INVALID_ACK_EN -- the arbiter acks strobes
// to undecoded addresses itself (data 0) so the master cannot hang.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] S0_BASE = 30'h0000_0000,
  parameter logic [ADDR_W-1:0] S0_MASK = 30'h3800_0000,
  parameter logic [ADDR_W-1:0] S1_BASE = 30'h3000_0000,
  parameter logic [ADDR_W-1:0] S1_MASK = 30'h3C00_0000,
  parameter logic [ADDR_W-1:0] S2_BASE = 30'h3C00_0000,
  parameter logic [ADDR_W-1:0] S2_MASK = 30'h3C00_0000
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  output logic        invalid_addr,
  // master 0
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:2] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  // master 1
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:2] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  // master 2
  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  input  logic        m2_we_i,
  input  logic [31:2] m2_addr_i,
  input  logic [2:0]  m2_cti_i,
  input  logic [1:0]  m2_bte_i,
  input  logic [3:0]  m2_sel_i,
  input  logic [31:0] m2_data_i,
  output logic [31:0] m2_data_o,
  output logic        m2_ack_o,
  // master 3
  input  logic        m3_cyc_i,
  input  logic        m3_stb_i,
  input  logic        m3_we_i,
  input  logic [31:2] m3_addr_i,
  input  logic [2:0]  m3_cti_i,
  input  logic [1:0]  m3_bte_i,
  input  logic [3:0]  m3_sel_i,
  input  logic [31:0] m3_data_i,
  output logic [31:0] m3_data_o,
  output logic        m3_ack_o,
  // slave 0
  output logic        s0_cyc_o,
  output logic        s0_stb_o,
  output logic        s0_we_o,
  output logic [31:2] s0_addr_o,
  output logic [2:0]  s0_cti_o,
  output logic [1:0]  s0_bte_o,
  output logic [3:0]  s0_sel_o,
  output logic [31:0] s0_data_o,
  input  logic [31:0] s0_data_i,
  input  logic        s0_ack_i,
  // slave 1
  output logic        s1_cyc_o,
  output logic        s1_stb_o,
  output logic        s1_we_o,
  output logic [31:2] s1_addr_o,
  output logic [2:0]  s1_cti_o,
  output logic [1:0]  s1_bte_o,
  output logic [3:0]  s1_sel_o,
  output logic [31:0] s1_data_o,
  input  logic [31:0] s1_data_i,
  input  logic        s1_ack_i,
  // slave 2
  output logic        s2_cyc_o,
  output logic        s2_stb_o,
  output logic        s2_we_o,
  output logic [31:2] s2_addr_o,
  output logic [2:0]  s2_cti_o,
  output logic [1:0]  s2_bte_o,
  output logic [3:0]  s2_sel_o,
  output logic [31:0] s2_data_o,
  input  logic [31:0] s2_data_i,
  input  logic        s2_ack_i
);

  // Master requests gathered into indexable form
  logic [NUM_MASTERS-1:0] m_cyc, m_stb, m_we;
  logic [ADDR_W-1:0]      m_addr [NUM_MASTERS];
  logic [2:0]             m_cti  [NUM_MASTERS];
  logic [1:0]             m_bte  [NUM_MASTERS];
  logic [3:0]             m_sel  [NUM_MASTERS];
  logic [DATA_W-1:0]      m_data [NUM_MASTERS];

  assign m_cyc = {m3_cyc_i, m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign m_stb = {m3_stb_i, m2_stb_i, m1_stb_i, m0_stb_i};
  assign m_we  = {m3_we_i,  m2_we_i,  m1_we_i,  m0_we_i};

  assign m_addr[0] = m0_addr_i;
  assign m_addr[1] = m1_addr_i;
  assign m_addr[2] = m2_addr_i;
  assign m_addr[3] = m3_addr_i;
  assign m_cti[0]  = m0_cti_i;
  assign m_cti[1]  = m1_cti_i;
  assign m_cti[2]  = m2_cti_i;
  assign m_cti[3]  = m3_cti_i;
  assign m_bte[0]  = m0_bte_i;
  assign m_bte[1]  = m1_bte_i;
  assign m_bte[2]  = m2_bte_i;
  assign m_bte[3]  = m3_bte_i;
  assign m_sel[0]  = m0_sel_i;
  assign m_sel[1]  = m1_sel_i;
  assign m_sel[2]  = m2_sel_i;
  assign m_sel[3]  = m3_sel_i;
  assign m_data[0] = m0_data_i;
  assign m_data[1] = m1_data_i;
  assign m_data[2] = m2_data_i;
  assign m_data[3] = m3_data_i;

  // Slave returns gathered into indexable form
  logic [NUM_SLAVES-1:0] s_ack;
  logic [DATA_W-1:0]     s_data [NUM_SLAVES];

  assign s_ack     = {s2_ack_i, s1_ack_i, s0_ack_i};
  assign s_data[0] = s0_data_i;
  assign s_data[1] = s1_data_i;
  assign s_data[2] = s2_data_i;

  grant_t grant_reg;

  // Grant FSM: hold while the owner keeps cyc, otherwise hand off to the
  // highest-priority requester (or idle) on the same edge
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      grant_reg <= GRANT_IDLE;
    end else begin
      case (grant_reg)
        GRANT_M0: if (!m_cyc[0]) grant_reg <= pick_grant(m_cyc);
        GRANT_M1: if (!m_cyc[1]) grant_reg <= pick_grant(m_cyc);
        GRANT_M2: if (!m_cyc[2]) grant_reg <= pick_grant(m_cyc);
        GRANT_M3: if (!m_cyc[3]) grant_reg <= pick_grant(m_cyc);
        default:  grant_reg <= pick_grant(m_cyc);
      endcase
    end
  end

  // One-hot owner; forced low while reset is asserted so a reset in the
  // middle of a transfer cuts the bus off without waiting for the edge
  logic [NUM_MASTERS-1:0] gnt_oh;

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_gnt
      assign gnt_oh[gi] = wb_rst && (grant_reg == grant_t'(3'(gi + 1)));
    end
  endgenerate

  // Granted master's request; all zero when nobody owns the bus
  logic              g_cyc, g_stb, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [2:0]        g_cti;
  logic [1:0]        g_bte;
  logic [3:0]        g_sel;
  logic [DATA_W-1:0] g_data;

  // Route the owner's request onto the shared slave-side bus
  always_comb begin
    g_cyc  = 1'b0;
    g_stb  = 1'b0;
    g_we   = 1'b0;
    g_addr = '0;
    g_cti  = CTI_CLASSIC;
    g_bte  = BTE_LINEAR;
    g_sel  = '0;
    g_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_oh[i]) begin
        g_cyc  = m_cyc[i];
        g_stb  = m_stb[i];
        g_we   = m_we[i];
        g_addr = m_addr[i];
        g_cti  = m_cti[i];
        g_bte  = m_bte[i];
        g_sel  = m_sel[i];
        g_data = m_data[i];
      end
    end
  end

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_invalid;

  wb_addr_dec #(
    .S0_BASE(S0_BASE),
    .S0_MASK(S0_MASK),
    .S1_BASE(S1_BASE),
    .S1_MASK(S1_MASK),
    .S2_BASE(S2_BASE),
    .S2_MASK(S2_MASK)
  ) u_dec (
    .addr   (g_addr),
    .sel    (dec_sel),
    .invalid(dec_invalid)
  );

  // Ack/data of the decoded slave; zero when the address hits no slave
  logic              sel_ack;
  logic [DATA_W-1:0] sel_data;

  // Pick the decoded slave's response
  always_comb begin
    sel_ack  = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (dec_sel[k]) begin
        sel_ack  = s_ack[k];
        sel_data = s_data[k];
      end
    end
  end

  assign invalid_addr = g_cyc & g_stb & dec_invalid;

  logic ret_ack;

`ifdef WB_ARB_INVALID_ACK_EN
  // Terminate strobes to holes in the map locally (read data stays 0)
  assign ret_ack = sel_ack | invalid_addr;
`else
  assign ret_ack = sel_ack;
`endif

  // Responses reach only the owning master
  assign m0_ack_o  = gnt_oh[0] & ret_ack;
  assign m1_ack_o  = gnt_oh[1] & ret_ack;
  assign m2_ack_o  = gnt_oh[2] & ret_ack;
  assign m3_ack_o  = gnt_oh[3] & ret_ack;
  assign m0_data_o = gnt_oh[0] ? sel_data : '0;
  assign m1_data_o = gnt_oh[1] ? sel_data : '0;
  assign m2_data_o = gnt_oh[2] ? sel_data : '0;
  assign m3_data_o = gnt_oh[3] ? sel_data : '0;

  // Slave side: handshake qualified by decode, payload broadcast
  assign s0_cyc_o  = g_cyc & dec_sel[0];
  assign s0_stb_o  = g_stb & dec_sel[0];
  assign s0_we_o   = g_we;
  assign s0_addr_o = g_addr;
  assign s0_cti_o  = g_cti;
  assign s0_bte_o  = g_bte;
  assign s0_sel_o  = g_sel;
  assign s0_data_o = g_data;

  assign s1_cyc_o  = g_cyc & dec_sel[1];
  assign s1_stb_o  = g_stb & dec_sel[1];
  assign s1_we_o   = g_we;
  assign s1_addr_o = g_addr;
  assign s1_cti_o  = g_cti;
  assign s1_bte_o  = g_bte;
  assign s1_sel_o  = g_sel;
  assign s1_data_o = g_data;

  assign s2_cyc_o  = g_cyc & dec_sel[2];
  assign s2_stb_o  = g_stb & dec_sel[2];
  assign s2_we_o   = g_we;
  assign s2_addr_o = g_addr;
  assign s2_cti_o  = g_cti;
  assign s2_bte_o  = g_bte;
  assign s2_sel_o  = g_sel;
  assign s2_data_o = g_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: arbitration sequence table, directed
// decode/data-path checks and randomized traffic against a reference model.
module tb_wb_arbiter;

  localparam logic [29:0] BASE0 = 30'h0000_0000, MASK0 = 30'h3800_0000;
  localparam logic [29:0] BASE1 = 30'h3000_0000, MASK1 = 30'h3C00_0000;
  localparam logic [29:0] BASE2 = 30'h3C00_0000, MASK2 = 30'h3C00_0000;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0]  m_cyc, m_stb, m_we;
  logic [29:0] m_addr [4];
  logic [2:0]  m_cti  [4];
  logic [1:0]  m_bte  [4];
  logic [3:0]  m_sel  [4];
  logic [31:0] m_wdata[4];
  logic [31:0] m_rdata[4];
  logic [3:0]  m_ack;

  logic [2:0]  s_cyc, s_stb, s_we, s_ack;
  logic [29:0] s_addr [3];
  logic [2:0]  s_cti  [3];
  logic [1:0]  s_bte  [3];
  logic [3:0]  s_sel  [3];
  logic [31:0] s_wdata[3];
  logic [31:0] s_rdata[3];
  logic        invalid;

  int n_tests = 0;
  int n_fail  = 0;
  int owner   = -1;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .wb_clk(clk), .wb_rst(rst_n), .invalid_addr(invalid),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_addr_i(m_addr[0]),
    .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]), .m0_sel_i(m_sel[0]), .m0_data_i(m_wdata[0]),
    .m0_data_o(m_rdata[0]), .m0_ack_o(m_ack[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_addr_i(m_addr[1]),
    .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]), .m1_sel_i(m_sel[1]), .m1_data_i(m_wdata[1]),
    .m1_data_o(m_rdata[1]), .m1_ack_o(m_ack[1]),
    .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]), .m2_we_i(m_we[2]), .m2_addr_i(m_addr[2]),
    .m2_cti_i(m_cti[2]), .m2_bte_i(m_bte[2]), .m2_sel_i(m_sel[2]), .m2_data_i(m_wdata[2]),
    .m2_data_o(m_rdata[2]), .m2_ack_o(m_ack[2]),
    .m3_cyc_i(m_cyc[3]), .m3_stb_i(m_stb[3]), .m3_we_i(m_we[3]), .m3_addr_i(m_addr[3]),
    .m3_cti_i(m_cti[3]), .m3_bte_i(m_bte[3]), .m3_sel_i(m_sel[3]), .m3_data_i(m_wdata[3]),
    .m3_data_o(m_rdata[3]), .m3_ack_o(m_ack[3]),
    .s0_cyc_o(s_cyc[0]), .s0_stb_o(s_stb[0]), .s0_we_o(s_we[0]), .s0_addr_o(s_addr[0]),
    .s0_cti_o(s_cti[0]), .s0_bte_o(s_bte[0]), .s0_sel_o(s_sel[0]), .s0_data_o(s_wdata[0]),
    .s0_data_i(s_rdata[0]), .s0_ack_i(s_ack[0]),
    .s1_cyc_o(s_cyc[1]), .s1_stb_o(s_stb[1]), .s1_we_o(s_we[1]), .s1_addr_o(s_addr[1]),
    .s1_cti_o(s_cti[1]), .s1_bte_o(s_bte[1]), .s1_sel_o(s_sel[1]), .s1_data_o(s_wdata[1]),
    .s1_data_i(s_rdata[1]), .s1_ack_i(s_ack[1]),
    .s2_cyc_o(s_cyc[2]), .s2_stb_o(s_stb[2]), .s2_we_o(s_we[2]), .s2_addr_o(s_addr[2]),
    .s2_cti_o(s_cti[2]), .s2_bte_o(s_bte[2]), .s2_sel_o(s_sel[2]), .s2_data_o(s_wdata[2]),
    .s2_data_i(s_rdata[2]), .s2_ack_i(s_ack[2])
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: first window whose masked address equals its base
  function automatic int decode(input logic [29:0] a);
    if ((a & MASK0) == BASE0) return 0;
    if ((a & MASK1) == BASE1) return 1;
    if ((a & MASK2) == BASE2) return 2;
    return -1;
  endfunction

  // Reference arbitration: keep the owner while it holds cyc, else lowest index requester
  function automatic int next_owner(input int cur, input logic [3:0] cyc, input logic rst);
    if (!rst) return -1;
    if (cur >= 0 && cyc[cur]) return cur;
    for (int i = 0; i < 4; i++) if (cyc[i]) return i;
    return -1;
  endfunction

  task automatic check_model(input int o_in);
    int o, d;
    logic [3:0]   e_ack;
    logic [127:0] e_rd, a_rd;
    logic [2:0]   e_cyc, e_stb;
    logic         e_inv, r_ack;
    logic [31:0]  r_data;
    logic [71:0]  e_bus;
    o = rst_n ? o_in : -1;
    e_ack = '0; e_rd = '0; e_cyc = '0; e_stb = '0; e_inv = 1'b0; e_bus = '0;
    if (o >= 0) begin
      d = decode(m_addr[o]);
      e_bus = {m_we[o], m_addr[o], m_cti[o], m_bte[o], m_sel[o], m_wdata[o]};
      r_ack = (d >= 0) ? s_ack[d] : 1'b0;
      r_data = (d >= 0) ? s_rdata[d] : 32'h0;
      if (d >= 0) begin
        e_cyc[d] = m_cyc[o];
        e_stb[d] = m_stb[o];
      end else begin
        e_inv = m_cyc[o] & m_stb[o];
`ifdef WB_ARB_INVALID_ACK_EN
        r_ack = e_inv;
`endif
      end
      e_ack[o] = r_ack;
      e_rd[o*32 +: 32] = r_data;
    end
    a_rd = {m_rdata[3], m_rdata[2], m_rdata[1], m_rdata[0]};
    check("rnd_m_ack", 128'(m_ack), 128'(e_ack));
    check("rnd_m_data", a_rd, e_rd);
    check("rnd_s_cyc", 128'(s_cyc), 128'(e_cyc));
    check("rnd_s_stb", 128'(s_stb), 128'(e_stb));
    check("rnd_invalid", 128'(invalid), 128'(e_inv));
    for (int k = 0; k < 3; k++)
      check("rnd_s_bus", 128'({s_we[k], s_addr[k], s_cti[k], s_bte[k], s_sel[k], s_wdata[k]}), 128'(e_bus));
  endtask

  function automatic logic [29:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 30'h0000_0004;
      1: return 30'h07FF_FFFF;
      2: return 30'h0800_0000;
      3: return 30'h3000_0000;
      4: return 30'h33FF_FFFF;
      5: return 30'h3400_0000;
      6: return 30'h3C00_0010;
      default: return 30'($urandom);
    endcase
  endfunction

  typedef struct {
    logic       rst_n;
    logic [3:0] cyc;
    logic [3:0] exp_ack;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Arbitration sequence; every master strobes slave 0, which always acks,
    // so the owner is the one master seeing ack after each edge
    tbl[0]  = '{1'b0, 4'b1111, 4'b0000};
    tbl[1]  = '{1'b1, 4'b0001, 4'b0001};
    tbl[2]  = '{1'b1, 4'b0011, 4'b0001};
    tbl[3]  = '{1'b1, 4'b0111, 4'b0001};
    tbl[4]  = '{1'b1, 4'b0101, 4'b0001};
    tbl[5]  = '{1'b1, 4'b0100, 4'b0100};
    tbl[6]  = '{1'b1, 4'b0110, 4'b0100};
    tbl[7]  = '{1'b1, 4'b0010, 4'b0010};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b1, 4'b1000, 4'b1000};
    tbl[10] = '{1'b1, 4'b1001, 4'b1000};
    tbl[11] = '{1'b0, 4'b1001, 4'b0000};
    tbl[12] = '{1'b1, 4'b1001, 4'b0001};
    tbl[13] = '{1'b1, 4'b0000, 4'b0000};

    rst_n = 1'b0;
    m_cyc = '0; m_stb = 4'b1111; m_we = '0;
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = 30'h4; m_cti[i] = 3'b000; m_bte[i] = 2'b00;
      m_sel[i] = 4'hF; m_wdata[i] = 32'h1000_0000 + i;
    end
    s_ack = 3'b111;
    for (int k = 0; k < 3; k++) s_rdata[k] = 32'hA000_0000 + k;

    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      rst_n = tbl[t].rst_n;
      m_cyc = tbl[t].cyc;
      @(posedge clk);
      #1;
      check("tbl_ack", 128'(m_ack), 128'(tbl[t].exp_ack));
      check("tbl_s0_cyc", 128'(s_cyc[0]), 128'(|tbl[t].exp_ack));
      $display("[TB] vec %0d rst_n=%0b cyc=%b ack=%b", t, tbl[t].rst_n, tbl[t].cyc, m_ack);
    end

    // m0 read from slave 0
    @(negedge clk);
    m_cyc = 4'b0011; m_stb = 4'b0011; m_addr[0] = 30'h4;
    s_ack = 3'b001; s_rdata[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("dir_s_cyc", 128'(s_cyc), 128'(3'b001));
    check("dir_s_stb", 128'(s_stb), 128'(3'b001));
    check("dir_m_ack", 128'(m_ack), 128'(4'b0001));
    check("dir_m0_data", 128'(m_rdata[0]), 128'(32'hDEADBEEF));
    check("dir_m1_data", 128'(m_rdata[1]), 128'(0));
    check("dir_invalid", 128'(invalid), 128'(0));
    $display("[TB] dir read s0 ack=%b data=%h", m_ack, m_rdata[0]);

    // Undecoded address 0x8000_0000
    @(negedge clk);
    m_addr[0] = 30'h2000_0000; #1;
    check("inv_flag", 128'(invalid), 128'(1));
    check("inv_s_cyc", 128'(s_cyc), 128'(3'b000));
`ifdef WB_ARB_INVALID_ACK_EN
    check("inv_ack", 128'(m_ack), 128'(4'b0001));
`else
    check("inv_ack", 128'(m_ack), 128'(4'b0000));
`endif
    check("inv_data", 128'(m_rdata[0]), 128'(0));
    $display("[TB] dir invalid flag=%0b ack=%b", invalid, m_ack);

    // Region boundaries and slave 1 / slave 2 routing
    m_addr[0] = 30'h07FF_FFFF; #1;
    check("bnd_s0_top", 128'({s_cyc, invalid}), 128'({3'b001, 1'b0}));
    m_addr[0] = 30'h0800_0000; #1;
    check("bnd_s0_over", 128'({s_cyc, invalid}), 128'({3'b000, 1'b1}));
    m_addr[0] = 30'h3000_0040; s_ack = 3'b010; s_rdata[1] = 32'hCAFEF00D; #1;
    check("dec_s1", 128'({s_cyc, m_ack, m_rdata[0]}), 128'({3'b010, 4'b0001, 32'hCAFEF00D}));
    m_addr[0] = 30'h3FFF_FFFF; s_ack = 3'b100; s_rdata[2] = 32'h1234_5678; #1;
    check("dec_s2", 128'({s_cyc, m_ack, m_rdata[0]}), 128'({3'b100, 4'b0001, 32'h1234_5678}));
    m_stb[0] = 1'b0; #1;
    check("no_stb", 128'({s_cyc, s_stb}), 128'({3'b100, 3'b000}));
    $display("[TB] dir decode s1/s2 boundaries");

    // Randomized traffic against the reference model
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    owner = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i] = 1'($urandom);
        m_we[i] = 1'($urandom);
        m_addr[i] = pick_addr();
        m_cti[i] = 3'($urandom);
        m_bte[i] = 2'($urandom);
        m_sel[i] = 4'($urandom);
        m_wdata[i] = $urandom;
      end
      s_ack = 3'($urandom);
      for (int k = 0; k < 3; k++) s_rdata[k] = $urandom;
      #1;
      check_model(owner);
      $display("[TB] rnd %0d rst_n=%0b cyc=%b owner=%0d ack=%b", n, rst_n, m_cyc, owner, m_ack);
      @(posedge clk);
      owner = next_owner(owner, m_cyc, rst_n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
